// File: rtl/fn_to_rec_fn_arb_pkg.sv
// rtl/fn_to_rec_fn_arb_pkg.sv - shared widths, class struct and bit positions for the converter arbiter
package fn_to_rec_fn_arb_pkg;

    function automatic int rec_width(input int exp_w, input int sig_w);
        return exp_w + sig_w + 1;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    typedef struct packed {
        logic nan;
        logic inf;
        logic sub;
        logic zero;
    } fp_class_t;

    localparam int CLASS_NAN  = 3;
    localparam int CLASS_INF  = 2;
    localparam int CLASS_SUB  = 1;
    localparam int CLASS_ZERO = 0;

endpackage

// File: rtl/fNToRecFN.sv
// rtl/fNToRecFN.sv - IEEE binary to recoded float conversion (exponent widened by one bit)
module fNToRecFN #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic [expWidth+sigWidth-1:0] in,
    output logic [expWidth+sigWidth:0]   out
);
    localparam int FW = sigWidth - 1;
    localparam int DW = $clog2(sigWidth);
    localparam logic [expWidth:0] BIAS_NORM = (expWidth+1)'((1 << (expWidth - 1)) | 1);
    localparam logic [expWidth:0] BIAS_SUB  = (expWidth+1)'((1 << (expWidth - 1)) | 2);

    logic                sign;
    logic [expWidth-1:0] exp_in;
    logic [FW-1:0]       fract_in;
    logic [DW-1:0]       norm_dist;
    logic [FW-1:0]       subnorm_fract;
    logic [expWidth:0]   adj_base;
    logic [expWidth:0]   adj_exp;
    logic [expWidth:0]   exp_out;
    logic                zero_exp;
    logic                zero_fract;
    logic                is_zero;
    logic                is_special;

    assign {sign, exp_in, fract_in} = in;
    assign zero_exp   = (exp_in == '0);
    assign zero_fract = (fract_in == '0);

    // Highest set bit wins, giving the leading-zero count of the fraction.
    always_comb begin
        norm_dist = DW'(FW);
        for (int i = 0; i < FW; i++) begin
            if (fract_in[i]) norm_dist = DW'(FW - 1 - i);
        end
    end

    assign subnorm_fract = (fract_in << norm_dist) << 1;
    assign adj_base      = zero_exp ? ~{{(expWidth+1-DW){1'b0}}, norm_dist} : {1'b0, exp_in};
    assign adj_exp       = adj_base + (zero_exp ? BIAS_SUB : BIAS_NORM);
    assign is_zero       = zero_exp && zero_fract;
    assign is_special    = (adj_exp[expWidth -: 2] == 2'b11);

    // Zero keeps an all-zero exponent field so +0 encodes as literal zero.
    assign exp_out[expWidth -: 3] = is_special ? {2'b11, !zero_fract}
                                  : is_zero    ? 3'b000
                                  : adj_exp[expWidth -: 3];
    assign exp_out[expWidth-3:0]  = is_zero ? '0 : adj_exp[expWidth-3:0];

    assign out = {sign, exp_out, zero_exp ? subnorm_fract : fract_in};

endmodule

// File: rtl/fn_to_rec_fn_arbiter_rr_arbiter.sv
// rtl/fn_to_rec_fn_arbiter_rr_arbiter.sv - round-robin grant with a pointer that moves past each winner
module rr_arbiter
    import fn_to_rec_fn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic                            en,
    input  logic                            advance,
    output logic [NUM_REQ-1:0]              grant,
    output logic [id_width(NUM_REQ)-1:0]    grant_idx
);
    localparam int IW = id_width(NUM_REQ);

    logic [IW-1:0] rr_ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
            idx = sum[IW-1:0];
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fn_to_rec_fn_arbiter.sv
// rtl/fn_to_rec_fn_arbiter.sv - shares one fNToRecFN among requesters; FN_TO_REC_FN_ARB_CLASSIFY_EN adds resp_class
module fn_to_rec_fn_arbiter
    import fn_to_rec_fn_arb_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int NUM_REQ   = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ*(EXP_WIDTH+SIG_WIDTH)-1:0]     req_data,
    output logic                                         resp_valid,
    input  logic                                         resp_ready,
    output logic [id_width(NUM_REQ)-1:0]                 resp_id,
    output logic [rec_width(EXP_WIDTH, SIG_WIDTH)-1:0]   resp_data
`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
    ,
    output logic [3:0]                                   resp_class
`endif
);
    localparam int IN_W  = EXP_WIDTH + SIG_WIDTH;
    localparam int REC_W = rec_width(EXP_WIDTH, SIG_WIDTH);
    localparam int IW    = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic [IN_W-1:0]    sel_data;
    logic               accept;
    logic               s1_valid;
    logic [IW-1:0]      s1_id;
    logic [IN_W-1:0]    s1_data;
    logic [REC_W-1:0]   s1_rec;
    logic               s2_load;
    logic               s1_free;

    assign s2_load = s1_valid && (!resp_valid || resp_ready);
    assign s1_free = !s1_valid || s2_load;

    // Gating the arbiter with reset keeps req_ready low while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .en        (s1_free && reset),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_data = sel_data | req_data[i*IN_W +: IN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_data  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= grant_idx;
            s1_data  <= sel_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    fNToRecFN #(.expWidth(EXP_WIDTH), .sigWidth(SIG_WIDTH)) u_conv (
        .in  (s1_data),
        .out (s1_rec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (s2_load) begin
            resp_valid <= 1'b1;
            resp_id    <= s1_id;
            resp_data  <= s1_rec;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [SIG_WIDTH-2:0] s1_fract;
    fp_class_t            s1_class;

    assign s1_exp   = s1_data[IN_W-2 -: EXP_WIDTH];
    assign s1_fract = s1_data[SIG_WIDTH-2:0];

    always_comb begin
        s1_class      = '0;
        s1_class.nan  = (s1_exp == '1) && (s1_fract != '0);
        s1_class.inf  = (s1_exp == '1) && (s1_fract == '0);
        s1_class.sub  = (s1_exp == '0) && (s1_fract != '0);
        s1_class.zero = (s1_exp == '0) && (s1_fract == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_class <= '0;
        end else if (s2_load) begin
            resp_class <= s1_class;
        end
    end
`endif

endmodule

// File: tb/tb_fn_to_rec_fn_arbiter.sv
// tb/tb_fn_to_rec_fn_arbiter.sv - directed and random scoreboard bench for fn_to_rec_fn_arbiter
module tb_fn_to_rec_fn_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [32:0]  resp_data;
    logic [3:0]   resp_class;

    typedef struct packed {
        logic [1:0]  id;
        logic [32:0] data;
        logic [3:0]  cls;
    } sb_entry_t;

    sb_entry_t  sb[$];
    logic [1:0] pop_log[$];
    int         errors = 0;
    int         checks = 0;
    int         acc_count = 0;
    logic       prev_hold = 1'b0;
    logic [32:0] prev_data;
    logic [1:0]  prev_id;

    always #5 clk = ~clk;

    fn_to_rec_fn_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
        .resp_class (resp_class),
`endif
        .resp_data  (resp_data)
    );

`ifndef FN_TO_REC_FN_ARB_CLASSIFY_EN
    assign resp_class = 4'b0000;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] golden(input logic [31:0] f);
        logic        s;
        int          e;
        logic [22:0] m;
        logic [22:0] t;
        int          nd;
        s = f[31];
        e = int'(f[30:23]);
        m = f[22:0];
        if (e == 255) return {s, 2'b11, (m != 23'd0), 6'd0, m};
        if (e == 0 && m == 23'd0) return {s, 32'd0};
        if (e == 0) begin
            nd = 0;
            while (!m[22-nd]) nd++;
            t = m << (nd + 1);
            return {s, 9'(129 - nd), t};
        end
        return {s, 9'(e + 129), m};
    endfunction

    function automatic logic [3:0] golden_cls(input logic [31:0] f);
        logic ex_ones;
        logic ex_zero;
        logic m_zero;
        ex_ones = (f[30:23] == 8'hFF);
        ex_zero = (f[30:23] == 8'h00);
        m_zero  = (f[22:0] == 23'd0);
        return {ex_ones && !m_zero, ex_ones && m_zero, ex_zero && !m_zero, ex_zero && m_zero};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic s;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 31'd0};
            1: return {s, 8'd0, (m == 23'd0) ? 23'd1 : m};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, (m == 23'd0) ? 23'd5 : m};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    task automatic rand_data();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = gen_operand();
    endtask

    // Monitor: pushes on accept, pops and compares on response handshake.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!reset) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (prev_hold) begin
                chk("bp_valid_held", 64'(resp_valid), 64'd1);
                chk("bp_stable_data", 64'(resp_data), 64'(prev_data));
                chk("bp_stable_id", 64'(resp_id), 64'(prev_id));
            end
            if (resp_valid && resp_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_data", 64'(resp_data), 64'(e.data));
`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
                    chk("resp_class", 64'(resp_class), 64'(e.cls));
`endif
                end
                pop_log.push_back(resp_id);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = golden(req_data[i*32 +: 32]);
                    e.cls  = golden_cls(req_data[i*32 +: 32]);
                    sb.push_back(e);
                    acc_count++;
                end
            end
            prev_hold = resp_valid && !resp_ready;
            prev_data = resp_data;
            prev_id   = resp_id;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int cyc;
        logic [1:0] exp_ids[5];
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        step(); step();
        req_valid = 4'hF;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        chk("reset_resp_id", 64'(resp_id), 64'd0);
        step();
        reset = 1'b1; req_valid = '0; resp_ready = 1'b1;

        // single request from requester 2
        req_data[2*32 +: 32] = 32'h3F80_0000;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_not_yet", 64'(resp_valid), 64'd0);
        step();
        @(negedge clk);
        chk("single_valid", 64'(resp_valid), 64'd1);
        chk("single_id", 64'(resp_id), 64'd2);
        chk("single_data", 64'(resp_data), 64'h0_8000_0000);
        step();

        // zero then infinity from requester 0
        req_data[31:0] = 32'h0000_0000;
        req_valid = 4'b0001;
        step();
        req_data[31:0] = 32'h7F80_0000;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("special_zero_data", 64'(resp_data), 64'h0);
`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
        chk("special_zero_class", 64'(resp_class), 64'b0001);
`endif
        step();
        @(negedge clk);
        chk("special_inf_data", 64'(resp_data), 64'h0_C000_0000);
`ifdef FN_TO_REC_FN_ARB_CLASSIFY_EN
        chk("special_inf_class", 64'(resp_class), 64'b0100);
`endif
        step(); step();

        // rotation from reset release
        reset = 1'b0; req_valid = 4'hF; rand_data();
        step();
        reset = 1'b1;
        pop_log.delete();
        repeat (5) begin
            @(negedge clk);
            chk("rot_one_ready", 64'($countones(req_ready)), 64'd1);
            step();
            rand_data();
        end
        req_valid = '0;
        repeat (3) step();
        chk("rot_count", 64'(pop_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("rot_id", 64'(pop_log[i]), 64'(exp_ids[i]));

        // backpressure with every requester valid
        resp_ready = 1'b0; req_valid = 4'hF;
        a0 = acc_count;
        repeat (5) begin
            @(negedge clk);
            step();
            rand_data();
        end
        chk("bp_accepts", 64'(acc_count - a0), 64'd2);
        @(negedge clk);
        chk("bp_ready_zero", 64'(req_ready), 64'd0);
        step();
        resp_ready = 1'b1; req_valid = '0;
        repeat (4) step();
        chk("bp_drain_empty", 64'(sb.size()), 64'd0);

        // reset while S1 and S2 are full
        resp_ready = 1'b0; req_valid = 4'hF; rand_data();
        repeat (3) step();
        reset = 1'b0; req_valid = 4'b1010;
        step();
        reset = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("rst_mid_drain", 64'(sb.size()), 64'd0);

        // random soak
        a0 = acc_count;
        cyc = 0;
        while ((acc_count - a0) < 10000 && cyc < 60000) begin
            req_valid  = 4'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
            cyc++;
        end
        chk("soak_accepted", 64'((acc_count - a0) >= 10000), 64'd1);
        req_valid = '0; resp_ready = 1'b1;
        repeat (4) step();
        chk("soak_drain_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
